btb_bht_assoc_v2: RTL
=====================

# btb_bht_assoc_v2

Parametrised set-associative branch target buffer with per-entry saturating-counter direction prediction. Its successor features are per-set tree pseudo-LRU, word-aligned indexing, and a reset/flush sweep state machine. IF performs a same-cycle lookup; MEM writes resolved branch/JAL outcomes back. An optional gshare pattern table replaces the per-entry counters.

## Interface
- NUM_SET_BITS, 4, log2 of set count; index = PC[NUM_SET_BITS+1:2]; tag = PC[31:NUM_SET_BITS+2]
- NUM_WAY_BITS, 2, log2 of ways per set (0 allowed = direct-mapped)
- CTR_BITS, 2, direction counter width (≥1)
- PHT_BITS, 8, gshare table index width (used only with BTB_GSHARE_EN)
- clk  in  1  clock; one clock domain
- rst  in  1  synchronous, active-high reset
- flush  in  1  starts invalidate sweep (e.g. fence.i / context switch)
- IF_PC  in  32  fetch PC
- hit  out  1  IF_PC matches a valid entry
- prediction  out  1  predicted taken (forced 1 when IF_is_jal)
- target_out  out  32  stored target of the hitting way
- IF_is_jal  out  1  hitting entry is an unconditional jump
- ready  out  1  sweep done; lookups/updates enabled
- MEM_PC  in  32  PC of resolved control-flow instruction
- update  in  1  MEM holds a resolved branch/JAL this cycle
- branch_result  in  1  resolved taken
- target_in  in  32  resolved target
- MEM_is_jal  in  1  resolved instruction is JAL

## Operation
- FSM states: SWEEP, READY. rst → SWEEP with set pointer 0; each SWEEP cycle clears valid bits and PLRU bits of one set (and counters of one gshare row group, if enabled); after set 2^NUM_SET_BITS−1 → READY. flush in READY → SWEEP with pointer 0.
- In SWEEP: hit=prediction=IF_is_jal=0, target_out=0, ready=0; updates are dropped.
- Lookup (combinational): a way hits when valid and tag equal. At most one way can hit (allocation never duplicates). No hit → all outputs 0.
- Update on hit in way w: counter saturating ±1 (taken +1, not-taken −1); target overwritten only if taken; is_jal rewritten; PLRU of that set marks w most recent.
- Update on miss, taken or MEM_is_jal: allocate lowest-index invalid way, else PLRU victim. Write tag, target, is_jal, valid=1, counter = weakly taken (1<<(CTR_BITS−1)). Touch PLRU.
- Update on miss and not-taken: no allocation, no state change.
- IF lookups never modify PLRU.
- Counter MSB is the prediction.

## Timing
- Reset values: hit 0, prediction 0, target_out 0, IF_is_jal 0, ready 0. ready rises exactly 2^NUM_SET_BITS cycles after the cycle in which rst is sampled low.
- Lookup latency 0 (same cycle as IF_PC). Update is committed at the clk edge and becomes visible to lookup the following cycle. There is no write-to-read bypass: IF to the same set in the same cycle sees the old contents.
- flush and update in the same cycle: flush wins and the update is dropped. rst mid-sweep restarts at set 0.
- flush during SWEEP restarts the sweep at set 0.
- Counter saturates at 0 and 2^CTR_BITS−1; no wrap.

## Configuration
- BTB_GSHARE_EN defined: the direction comes from a 2^PHT_BITS-entry counter table indexed by IF_PC[PHT_BITS+1:2] XOR GHR. The PHT_BITS-wide GHR shifts in branch_result on every non-JAL update (MEM index uses MEM_PC XOR the GHR value at update time). GHR and table reset to 0 / weakly taken during the sweep. Per-entry counters are not instantiated.
- Undefined: per-entry counters as above; no GHR.

## Structure
- Package btb_pkg: enum btb_state_t {BTB_SWEEP, BTB_READY}; function sat_ctr_next(ctr, taken, width); constant for the weakly-taken init. The entry struct stays local because its widths depend on parameters.
- Sub-module btb_plru_tree: per-set tree PLRU. Parameters NUM_WAY_BITS and NUM_SET_BITS. Ports: touch, touch_set, touch_way, query_set, victim, clear_set.

## Test plan
- Reset: hold rst 3 cycles, release. Expect ready=0 for 16 cycles then 1, and hit=0 for any IF_PC.
- Allocate/hit: update MEM_PC=0x100, taken, target_in=0x200. Next cycle IF_PC=0x100 → hit=1, target_out=0x200, prediction=1. Two not-taken updates → prediction=0. A third → counter stays 0.
- Not-taken miss: update MEM_PC=0x300, not-taken → IF_PC=0x300 hit=0.
- Replacement: 5 taken branches to set 0 (PCs 0x000, 0x040, 0x080, 0x0C0, 0x100; 4 ways), with 0x040 re-updated before the 5th. The 5th evicts the PLRU victim and 0x040 still hits.
- JAL: update MEM_is_jal=1, not-taken flag, MEM_PC=0x500 → IF_is_jal=1, prediction=1.
- Flush collision: flush and update asserted together → ready=0 for 16 cycles, and the updated PC does not hit afterward.

Source files
------------

// File: rtl/btb_pkg.sv
// ---------------------------------------------------------------------------
// btb_pkg
// Shared types and helpers for the btb_bht_assoc_v2 branch target buffer.
//   btb_state_t    : sweep / ready state encoding
//   sat_ctr_next   : saturating up/down counter step for any width
//   ctr_weak_taken : weakly-taken counter value for any width
// The per-entry struct is kept out of this package because its field widths
// depend on the top module's parameters.
// ---------------------------------------------------------------------------
package btb_pkg;

  typedef enum logic [0:0] {
    BTB_SWEEP = 1'b0,
    BTB_READY = 1'b1
  } btb_state_t;

  // Counter step: taken moves up, not-taken moves down, both clamp at the
  // ends of the range so a strongly biased branch never flips on wrap.
  function automatic logic [31:0] sat_ctr_next(input logic [31:0] ctr,
                                               input logic        taken,
                                               input int          width);
    logic [31:0] maxVal;
    maxVal = (32'd1 << width) - 32'd1;
    if (taken) begin
      return (ctr >= maxVal) ? maxVal : ctr + 32'd1;
    end
    return (ctr == 32'd0) ? 32'd0 : ctr - 32'd1;
  endfunction

  // Weakly taken = only the MSB set, so a fresh entry predicts taken but a
  // single not-taken outcome flips it.
  function automatic logic [31:0] ctr_weak_taken(input int width);
    return 32'd1 << (width - 1);
  endfunction

endpackage

// File: rtl/btb_plru_tree.sv
// ---------------------------------------------------------------------------
// btb_plru_tree
// Per-set tree pseudo-LRU state for a 2^NUM_WAY_BITS-way cache.
// Ports:
//   clk       : clock
//   touch     : mark touch_way of touch_set as most recently used
//   touch_set : set being touched
//   touch_way : way being touched
//   query_set : set whose replacement victim is reported
//   victim    : PLRU victim way of query_set (combinational)
//   clear     : reset the tree bits of clear_set (victim becomes way 0)
//   clear_set : set being cleared
// With NUM_WAY_BITS = 0 the cache is direct-mapped and the victim is way 0.
// ---------------------------------------------------------------------------
module btb_plru_tree #(
  parameter int NUM_WAY_BITS = 2,
  parameter int NUM_SET_BITS = 4
) (
  input  logic                                              clk,
  input  logic                                              touch,
  input  logic [NUM_SET_BITS-1:0]                           touch_set,
  input  logic [((NUM_WAY_BITS > 0) ? NUM_WAY_BITS : 1)-1:0] touch_way,
  input  logic [NUM_SET_BITS-1:0]                           query_set,
  output logic [((NUM_WAY_BITS > 0) ? NUM_WAY_BITS : 1)-1:0] victim,
  input  logic                                              clear,
  input  logic [NUM_SET_BITS-1:0]                           clear_set
);

  localparam int NUM_SETS = 1 << NUM_SET_BITS;

  generate
    if (NUM_WAY_BITS == 0) begin : g_direct
      logic w_unused;
      assign w_unused = ^{clk, touch, touch_set, touch_way, query_set, clear, clear_set};
      assign victim   = 1'b0;
    end else begin : g_tree
      localparam int NODES = (1 << NUM_WAY_BITS) - 1;

      // Heap-ordered node bits: node n has children 2n+1 (left) and 2n+2
      // (right). A bit of 0 sends the victim search left, 1 sends it right.
      logic [NODES-1:0]        r_tree [NUM_SETS];
      logic [NODES-1:0]        w_touchBits;
      logic [NUM_WAY_BITS-1:0] w_victim;

      // Walk the touched way's path and point every node on it away from
      // the touched way; nodes off the path keep their old value.
      always_comb begin
        logic [NUM_WAY_BITS-1:0] node;
        logic                    b;
        w_touchBits = r_tree[touch_set];
        node        = '0;
        for (int lvl = 0; lvl < NUM_WAY_BITS; lvl++) begin
          b                 = touch_way[NUM_WAY_BITS-1-lvl];
          w_touchBits[node] = ~b;
          node              = NUM_WAY_BITS'((32'(node) << 1) + 32'd1 + 32'(b));
        end
      end

      // Follow the node bits from the root; each bit taken is one victim bit.
      always_comb begin
        logic [NUM_WAY_BITS-1:0] node;
        logic                    b;
        w_victim = '0;
        node     = '0;
        for (int lvl = 0; lvl < NUM_WAY_BITS; lvl++) begin
          b                                = r_tree[query_set][node];
          w_victim[NUM_WAY_BITS-1-lvl]     = b;
          node                             = NUM_WAY_BITS'((32'(node) << 1) + 32'd1 + 32'(b));
        end
      end

      assign victim = w_victim;

      always_ff @(posedge clk) begin
        if (clear) begin
          r_tree[clear_set] <= '0;
        end else if (touch) begin
          r_tree[touch_set] <= w_touchBits;
        end
      end
    end
  endgenerate

endmodule

// File: rtl/btb_bht_assoc_v2.sv
// ---------------------------------------------------------------------------
// btb_bht_assoc_v2
// Set-associative branch target buffer with saturating-counter direction
// prediction, tree pseudo-LRU replacement and a set-by-set invalidate sweep
// after reset or flush.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   flush         : restart the invalidate sweep (fence.i / context switch)
//   IF_PC         : fetch PC, looked up combinationally
//   hit           : IF_PC matches a valid entry
//   prediction    : predicted taken (always 1 for a jump entry)
//   target_out    : stored target of the hitting way
//   IF_is_jal     : hitting entry is an unconditional jump
//   ready         : sweep finished, lookups and updates enabled
//   MEM_PC        : PC of the resolved control-flow instruction
//   update        : MEM holds a resolved branch/JAL this cycle
//   branch_result : resolved taken
//   target_in     : resolved target
//   MEM_is_jal    : resolved instruction is a JAL
// Optional feature macro: BTB_GSHARE_EN replaces the per-entry counters with
// a global-history-xor-PC indexed pattern table.
// ---------------------------------------------------------------------------
module btb_bht_assoc_v2
  import btb_pkg::*;
#(
  parameter int NUM_SET_BITS = 4,
  parameter int NUM_WAY_BITS = 2,
  parameter int CTR_BITS     = 2,
  parameter int PHT_BITS     = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic [31:0] IF_PC,
  output logic        hit,
  output logic        prediction,
  output logic [31:0] target_out,
  output logic        IF_is_jal,
  output logic        ready,
  input  logic [31:0] MEM_PC,
  input  logic        update,
  input  logic        branch_result,
  input  logic [31:0] target_in,
  input  logic        MEM_is_jal
);

  localparam int NUM_SETS = 1 << NUM_SET_BITS;
  localparam int NUM_WAYS = 1 << NUM_WAY_BITS;
  localparam int TAG_BITS = 30 - NUM_SET_BITS;
  localparam int WB       = (NUM_WAY_BITS > 0) ? NUM_WAY_BITS : 1;

  localparam logic [0:0]              S_SWEEP = 1'(BTB_SWEEP);
  localparam logic [0:0]              S_READY = 1'(BTB_READY);
  localparam logic [NUM_SET_BITS-1:0] SET_MAX = '1;

  // FSM and sweep pointer
  logic [0:0]              r_state;
  logic [NUM_SET_BITS-1:0] r_ptr;

  // Entry storage
  logic                r_valid  [NUM_SETS][NUM_WAYS];
  logic [TAG_BITS-1:0] r_tag    [NUM_SETS][NUM_WAYS];
  logic [31:0]         r_target [NUM_SETS][NUM_WAYS];
  logic                r_isJal  [NUM_SETS][NUM_WAYS];

  // Address split; PC[1:0] never takes part in indexing
  logic [NUM_SET_BITS-1:0] w_ifSet, w_memSet;
  logic [TAG_BITS-1:0]     w_ifTag, w_memTag;
  logic                    w_unused;

  assign w_ifSet  = IF_PC[NUM_SET_BITS+1:2];
  assign w_ifTag  = IF_PC[31:NUM_SET_BITS+2];
  assign w_memSet = MEM_PC[NUM_SET_BITS+1:2];
  assign w_memTag = MEM_PC[31:NUM_SET_BITS+2];
  assign w_unused = ^{IF_PC[1:0], MEM_PC[1:0]};

  logic          w_ready, w_sweep;
  logic          w_ifHit, w_memHit, w_invFound;
  logic [WB-1:0] w_ifWay, w_memHitWay, w_invWay, w_victim, w_updWay;
  logic          w_updEn, w_hitUpd, w_alloc, w_touch;
  logic          w_dirTaken;
  logic [CTR_BITS-1:0] w_ctrNext, w_ctrWeak;

  assign w_ready = (r_state == S_READY);
  assign w_sweep = (r_state == S_SWEEP);

  // Fetch-side tag match; allocation never duplicates a tag, so at most one
  // way can match and the loop order does not matter.
  always_comb begin
    w_ifHit = 1'b0;
    w_ifWay = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (r_valid[w_ifSet][w] && (r_tag[w_ifSet][w] == w_ifTag)) begin
        w_ifHit = 1'b1;
        w_ifWay = WB'(w);
      end
    end
  end

  // MEM-side tag match plus the lowest-index invalid way (the downward loop
  // lets the lowest index overwrite any higher one).
  always_comb begin
    w_memHit    = 1'b0;
    w_memHitWay = '0;
    w_invFound  = 1'b0;
    w_invWay    = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (r_valid[w_memSet][w] && (r_tag[w_memSet][w] == w_memTag)) begin
        w_memHit    = 1'b1;
        w_memHitWay = WB'(w);
      end
    end
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (!r_valid[w_memSet][w]) begin
        w_invFound = 1'b1;
        w_invWay   = WB'(w);
      end
    end
  end

  // flush and rst both override an update arriving in the same cycle.
  assign w_updEn   = update & w_ready & ~flush & ~rst;
  assign w_hitUpd  = w_updEn & w_memHit;
  assign w_alloc   = w_updEn & ~w_memHit & (branch_result | MEM_is_jal);
  assign w_touch   = w_hitUpd | w_alloc;
  assign w_updWay  = w_memHit ? w_memHitWay : (w_invFound ? w_invWay : w_victim);
  assign w_ctrWeak = CTR_BITS'(ctr_weak_taken(CTR_BITS));

  btb_plru_tree #(
    .NUM_WAY_BITS (NUM_WAY_BITS),
    .NUM_SET_BITS (NUM_SET_BITS)
  ) u_plru (
    .clk       (clk),
    .touch     (w_touch),
    .touch_set (w_memSet),
    .touch_way (w_updWay),
    .query_set (w_memSet),
    .victim    (w_victim),
    .clear     (w_sweep),
    .clear_set (r_ptr)
  );

`ifdef BTB_GSHARE_EN
  localparam int PHT_SIZE  = 1 << PHT_BITS;
  localparam int PHT_GROUP = (PHT_SIZE > NUM_SETS) ? (PHT_SIZE / NUM_SETS) : 1;

  logic [PHT_BITS-1:0] r_ghr;
  logic [CTR_BITS-1:0] r_pht [PHT_SIZE];
  logic [PHT_BITS-1:0] w_ifPht, w_memPht;

  assign w_ifPht    = IF_PC[PHT_BITS+1:2] ^ r_ghr;
  assign w_memPht   = MEM_PC[PHT_BITS+1:2] ^ r_ghr;
  assign w_dirTaken = r_pht[w_ifPht][CTR_BITS-1];
  assign w_ctrNext  = CTR_BITS'(sat_ctr_next(32'(r_pht[w_memPht]), branch_result, CTR_BITS));

  // The sweep reinitialises one group of table rows per set cycle, so the
  // whole table is weakly taken by the time the sweep finishes. JAL updates
  // leave both history and table alone.
  always_ff @(posedge clk) begin
    if (w_sweep) begin
      r_ghr <= '0;
      for (int g = 0; g < PHT_GROUP; g++) begin
        if ((int'(r_ptr) * PHT_GROUP + g) < PHT_SIZE) begin
          r_pht[PHT_BITS'(int'(r_ptr) * PHT_GROUP + g)] <= w_ctrWeak;
        end
      end
    end else if (w_updEn && !MEM_is_jal) begin
      r_pht[w_memPht] <= w_ctrNext;
      r_ghr           <= PHT_BITS'({r_ghr, branch_result});
    end
  end
`else
  logic [CTR_BITS-1:0] r_ctr [NUM_SETS][NUM_WAYS];

  assign w_dirTaken = r_ctr[w_ifSet][w_ifWay][CTR_BITS-1];
  assign w_ctrNext  = CTR_BITS'(sat_ctr_next(32'(r_ctr[w_memSet][w_updWay]), branch_result, CTR_BITS));

  always_ff @(posedge clk) begin
    if (w_alloc) begin
      r_ctr[w_memSet][w_updWay] <= w_ctrWeak;
    end else if (w_hitUpd) begin
      r_ctr[w_memSet][w_updWay] <= w_ctrNext;
    end
  end
`endif

  // Outputs are forced to zero while sweeping; jumps always predict taken.
  assign ready      = w_ready;
  assign hit        = w_ready & w_ifHit;
  assign IF_is_jal  = hit & r_isJal[w_ifSet][w_ifWay];
  assign prediction = hit & (r_isJal[w_ifSet][w_ifWay] | w_dirTaken);
  assign target_out = hit ? r_target[w_ifSet][w_ifWay] : 32'd0;

  // Sweep state machine: one set per cycle, flush or rst restart at set 0.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_state <= S_SWEEP;
      r_ptr   <= '0;
    end else if (r_state == S_SWEEP) begin
      r_ptr <= r_ptr + 1'b1;
      if (r_ptr == SET_MAX) begin
        r_state <= S_READY;
      end
    end
  end

  // Valid bits: cleared by the sweep, set by allocation.
  always_ff @(posedge clk) begin
    if (w_sweep) begin
      for (int w = 0; w < NUM_WAYS; w++) begin
        r_valid[r_ptr][w] <= 1'b0;
      end
    end else if (w_alloc) begin
      r_valid[w_memSet][w_updWay] <= 1'b1;
    end
  end

  // Entry payload: a not-taken outcome keeps the old target so a loop exit
  // does not destroy the loop-back target.
  always_ff @(posedge clk) begin
    if (w_alloc) begin
      r_tag[w_memSet][w_updWay]    <= w_memTag;
      r_target[w_memSet][w_updWay] <= target_in;
      r_isJal[w_memSet][w_updWay]  <= MEM_is_jal;
    end else if (w_hitUpd) begin
      if (branch_result) begin
        r_target[w_memSet][w_updWay] <= target_in;
      end
      r_isJal[w_memSet][w_updWay] <= MEM_is_jal;
    end
  end

endmodule
